// File: rtl/pulse_scheduler.sv
// Round-robin pulse scheduler: four requesters share one pulse line; each grant
// produces one high phase, one low phase, then a one-cycle done acknowledge.
module pulse_scheduler #(
    parameter int N  = 4,
    parameter int LW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] high_len,
    input  logic [LW-1:0] low_len,
    output logic          signal,
    output logic [N-1:0]  grant,
    output logic [N-1:0]  done,
    output logic          busy
);

    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t        state_reg,  state_next;
    logic [LW-1:0] cnt_reg,    cnt_next;
    logic [LW-1:0] lo_reg,     lo_next;
    logic [PW-1:0] last_reg,   last_next;
    logic          signal_reg, signal_next;
    logic [N-1:0]  grant_reg,  grant_next;
    logic [N-1:0]  done_reg,   done_next;

    // Rotated view of the requests: slot gi holds requester (last+1+gi) mod N.
    logic [PW-1:0] rot_idx [N];
    logic [N-1:0]  rot_req;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot_idx[gi] = last_reg + PW'(gi + 1);
            assign rot_req[gi] = req[rot_idx[gi]];
        end
    endgenerate

    // Lowest rotated slot wins, so scan from the top down.
    logic [PW-1:0] win_idx;
    always_comb begin
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                win_idx = rot_idx[i];
            end
        end
    end

    logic          any_req;
    logic [LW-1:0] eff_high;
    logic [LW-1:0] eff_low;

    assign any_req  = |req;
    assign eff_high = (high_len == '0) ? LW'(1) : high_len;
    assign eff_low  = (low_len  == '0) ? LW'(1) : low_len;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        lo_next     = lo_reg;
        last_next   = last_reg;
        signal_next = signal_reg;
        grant_next  = grant_reg;
        done_next   = '0;

        case (state_reg)
            IDLE: begin
                signal_next = 1'b0;
                grant_next  = '0;
                if (any_req) begin
                    state_next          = HIGH;
                    grant_next[win_idx] = 1'b1;
                    last_next           = win_idx;
                    signal_next         = 1'b1;
                    cnt_next            = eff_high - 1'b1;
                    lo_next             = eff_low;
                end
            end
            HIGH: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    signal_next = 1'b0;
                    cnt_next    = lo_reg - 1'b1;
                    state_next  = LOW;
                end
            end
            LOW: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    grant_next = '0;
                    done_next  = grant_reg;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next  = IDLE;
                signal_next = 1'b0;
                grant_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            lo_reg     <= '0;
            last_reg   <= PW'(N - 1);
            signal_reg <= 1'b0;
            grant_reg  <= '0;
            done_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            lo_reg     <= lo_next;
            last_reg   <= last_next;
            signal_reg <= signal_next;
            grant_reg  <= grant_next;
            done_reg   <= done_next;
        end
    end

    assign signal = signal_reg;
    assign grant  = grant_reg;
    assign done   = done_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: doc/pulse_scheduler.md
# pulse_scheduler

Round-robin scheduler that shares one pulse output among four requesters. Each granted requester receives exactly one pulse: `signal` is high for a programmable number of cycles, then low for a programmable gap. The scheduler then acknowledges the requester and rearbitrates. It sits between requesting test or stimulus blocks and the shared pulse line that feeds waveform dumps and downstream logic.

## Interface

Parameters:
- `N` (default 4): number of requesters. Fixed at 4 for this revision.
- `LW` (default 4): width of the length fields in bits.

Ports:
- `clock`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `req`  input  N  per-requester request level, held until the matching `done`.
- `high_len`  input  LW  high-phase length in cycles. Sampled only at grant.
- `low_len`  input  LW  low-phase length in cycles. Sampled only at grant.
- `signal`  output  1  shared pulse output, registered.
- `grant`  output  N  one-hot owner of the pulse line, registered. All zero when idle.
- `done`  output  N  one-cycle one-hot completion acknowledge, registered.
- `busy`  output  1  high in HIGH and LOW states.

## Operation

- FSM has three states: IDLE, HIGH, LOW.
- Internal state:
  - down-counter `cnt` (LW bits);
  - latched `lo` (LW bits);
  - round-robin pointer `last` (2 bits, index of the last requester served).
- Length rule: a length of 0 is treated as 1. Effective length = max(len, 1). Maximum is 2^LW−1 = 15.
- Arbitration: the search starts at `(last+1) mod 4` and ascends with wrap-around. The first set `req` bit wins.
- IDLE with any `req` set, on the next edge:
  - grant the winner;
  - set `last` to the winner;
  - set `signal` to 1;
  - load `cnt` with effHigh−1;
  - latch `lo` = effLow;
  - go to HIGH.
- IDLE with no `req`: hold state. `signal`=0, `grant`=0.
- HIGH:
  - `cnt`≠0: decrement.
  - `cnt`=0: set `signal` to 0, load `cnt` with `lo`−1, go to LOW.
- LOW:
  - `cnt`≠0: decrement.
  - `cnt`=0: clear `grant`, set `done` to the granted one-hot, go to IDLE.
- `done` clears on the following edge unconditionally.
- Requests are level-sensitive.
  - A requester must drop `req` in the cycle `done` is high. If it does not, it is treated as a new request. Round-robin ordering still serves others first.
  - Withdrawing `req` mid-service is ignored; the service runs to completion.
  - A `req` bit already set while another requester is being served waits; it is never lost.
- Changes to `high_len` or `low_len` during HIGH or LOW have no effect on the current service.
- Reset (asynchronous, any state, including mid-pulse):
  - immediately forces `signal`=0, `grant`=0, `done`=0, `busy`=0;
  - sets state to IDLE, `cnt`=0, `lo`=0, `last`=3 (requester 0 has first priority after reset).
- After reset deasserts, the first arbitration occurs on the first rising edge on which `req` is non-zero.

## Timing

- Grant latency: `req` sampled high in IDLE at edge k gives `grant` and `signal`=1 visible after edge k.
- `signal` high for exactly effHigh cycles, then low for exactly effLow cycles while `grant` is held.
- `done` is high for the one IDLE cycle that follows the LOW phase. That IDLE cycle also arbitrates.
- Back-to-back service period per requester: effHigh + effLow + 1 cycles.
- Minimum period, with both lengths 0 or 1: 3 cycles (H, L, IDLE).
- `busy` equals (state≠IDLE). `grant` is non-zero exactly when `busy` is high.
- No combinational path from inputs to outputs.

## Test plan

- Reset then single request: `req`=0001, high_len=3, low_len=2. Required response:
  - `grant`=0001 one cycle after the sampling edge;
  - `signal` high for 3 cycles, then low for 2;
  - `done`=0001 for one cycle;
  - `busy` high for exactly 5 cycles.
- Round-robin fairness: `req`=1111 held permanently, lengths 1/1. Required response:
  - grants cycle 0001, 0010, 0100, 1000, 0001, … ;
  - each service lasts 3 cycles;
  - no requester is skipped.
- Zero lengths: high_len=0, low_len=0. Required response: `signal` high for 1 cycle and low for 1 cycle, `done` on the 3rd cycle after grant.
- Config change mid-pulse: grant with high_len=5, then set high_len=1 on the 2nd HIGH cycle. Required response: `signal` still high for 5 cycles.
- Asynchronous reset mid-HIGH: assert `reset` between edges during HIGH. Required response:
  - `signal`, `grant` and `busy` drop to 0 without waiting for a clock edge;
  - no `done` is produced;
  - after release with `req`=1010, requester 1 is served first.
- Late request and withdrawal: requester 2 holds `req`, and requester 0 raises `req` mid-service of 2 and then withdraws it. Required response:
  - requester 2 completes normally;
  - requester 0 is still granted next if its `req` is high in the `done` cycle; otherwise the scheduler returns to IDLE.
